// File: rtl/mean_engine_param.sv
// Streams 2^len_log2 samples from a synchronous-read memory and reports mean/min/max/sum.
// Latency: done pulses in the cycle after start-edge + N + 2 (N = 2^len_log2, clamped to 2^ADDR_W).
// Backpressure: start is only accepted while ready=1; starts during a run are dropped, not queued.
// Optional rounded mean (round half up) when MEAN_ROUND_EN is defined; truncating mean otherwise.
module mean_engine_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RES_W  = DATA_W + ADDR_W,
  localparam int LEN_W = $clog2(ADDR_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [LEN_W-1:0]  i_len_log2,
  input  logic [ADDR_W-1:0] i_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_ready,
  output logic              o_done,
  output logic [RES_W-1:0]  o_result
);

  localparam logic [1:0] MODE_MEAN = 2'b00;
  localparam logic [1:0] MODE_MIN  = 2'b01;
  localparam logic [1:0] MODE_MAX  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [1:0]         r_mode;
  logic [LEN_W-1:0]   r_len;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_cnt;
  logic               r_vld;    // rd_data on this cycle belongs to the current run
  logic               r_first;  // next consumed sample seeds min/max
  logic [RES_W-1:0]   r_sum;
  logic [DATA_W-1:0]  r_min;
  logic [DATA_W-1:0]  r_max;
  logic [RES_W-1:0]   r_result;
  logic               r_done;

  logic [LEN_W-1:0]   w_len_clamped;
  logic [ADDR_W-1:0]  w_cnt_max;
  logic               w_last;
  logic [RES_W:0]     w_bias;
  logic [RES_W-1:0]   w_mean;
  logic [RES_W-1:0]   w_res;

  // Run length exponents beyond the address space collapse to a full sweep
  assign w_len_clamped = (i_len_log2 > LEN_W'(ADDR_W)) ? LEN_W'(ADDR_W) : i_len_log2;

  // Index of the final read: N-1, computed one bit wider so N = 2^ADDR_W works
  assign w_cnt_max = ADDR_W'(((ADDR_W+1)'(1) << r_len) - (ADDR_W+1)'(1));
  assign w_last    = (r_cnt == w_cnt_max);

  // Mean bias: half an LSB of the shifted result when rounding, nothing otherwise
  always_comb begin
    w_bias = '0;
`ifdef MEAN_ROUND_EN
    if (r_len != '0) begin
      w_bias = (RES_W+1)'(1) << (r_len - LEN_W'(1));
    end
`endif
  end

  // Extra headroom bit keeps sum + bias from overflowing before the shift
  assign w_mean = RES_W'(({1'b0, r_sum} + w_bias) >> r_len);

  // Select the statistic requested at start; min/max are zero-extended
  always_comb begin
    w_res = r_sum;
    case (r_mode)
      MODE_MEAN: w_res = w_mean;
      MODE_MIN:  w_res = RES_W'(r_min);
      MODE_MAX:  w_res = RES_W'(r_max);
      default:   w_res = r_sum;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: one issue cycle per sample, then drain the last read, then publish
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_RUN;
      S_RUN:    if (w_last)  w_next = S_DRAIN;
      S_DRAIN:  w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; address is parked at zero outside RUN
  always_comb begin
    o_ready   = 1'b0;
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    case (r_state)
      S_IDLE: o_ready = 1'b1;
      S_RUN: begin
        o_rd_en   = 1'b1;
        o_rd_addr = r_base + r_cnt;
      end
      default: ;
    endcase
  end

  // Latch run parameters at start; otherwise advance the issue counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= '0;
      r_len  <= '0;
      r_base <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_mode <= i_mode;
      r_len  <= w_len_clamped;
      r_base <= i_base;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt + ADDR_W'(1);
    end
  end

  // Track which cycles carry returned read data (memory has one cycle of latency)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
    end else begin
      r_vld <= (r_state == S_RUN);
    end
  end

  // Accumulate sum and track min/max; cleared at each accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_first <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_first <= 1'b1;
    end else if (r_vld) begin
      r_sum   <= r_sum + RES_W'(i_rd_data);
      r_first <= 1'b0;
      if (r_first || i_rd_data < r_min) r_min <= i_rd_data;
      if (r_first || i_rd_data > r_max) r_max <= i_rd_data;
    end
  end

  // Publish the result and a one-cycle done as FINISH is left; result holds afterwards
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      if (r_state == S_FINISH) r_result <= w_res;
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_mean_engine_param.sv
// Self-checking bench for mean_engine_param (DATA_W=8, ADDR_W=5): table vectors,
// hand-written back-to-back and mid-run reset sequences, and randomized runs
// checked against a plain-arithmetic reference model.
module tb_mean_engine_param;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [2:0]  i_len_log2;
  logic [4:0]  i_base;
  logic        o_rd_en;
  logic [4:0]  o_rd_addr;
  logic [7:0]  i_rd_data;
  logic        o_ready;
  logic        o_done;
  logic [12:0] o_result;

  mean_engine_param dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_len_log2 (i_len_log2),
    .i_base     (i_base),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_ready    (o_ready),
    .o_done     (o_done),
    .o_result   (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:31];
  logic [4:0] addr_q [$];
  int errors = 0;
  int checks = 0;

  // Synchronous-read memory: data appears one cycle after the read strobe
  always @(posedge clk) begin
    if (o_rd_en) i_rd_data <= mem[o_rd_addr];
  end

  // Log every issued read address
  always @(negedge clk) begin
    if (o_rd_en) addr_q.push_back(o_rd_addr);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int a = 0; a < 32; a++) begin
      case (kind)
        1:       mem[a] = 8'd255;
        3:       mem[a] = 8'($urandom_range(0, 255));
        default: mem[a] = 8'(a);
      endcase
    end
    if (kind == 2) mem[7] = 8'd200;
  endtask

  // Reference model straight from the statistic definitions
  function automatic int model(input int m, input int l, input int b);
    int eff, n, s, mn, mx, v;
    eff = (l > 5) ? 5 : l;
    n = 1 << eff;
    s = 0; mn = 256; mx = -1;
    for (int i = 0; i < n; i++) begin
      v = int'(mem[(b + i) % 32]);
      s += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    case (m)
`ifdef MEAN_ROUND_EN
      0: return (s + ((eff == 0) ? 0 : (1 << (eff - 1)))) / n;
`else
      0: return s / n;
`endif
      1: return mn;
      2: return mx;
      default: return s;
    endcase
  endfunction

  // One complete run from IDLE; called at a negedge; returns result and observations
  task automatic do_run(input int m, input int l, input int b, output int res,
                        output int lat, output int nrd, output int addr_ok);
    int n, k;
    addr_q.delete();
    i_mode = 2'(m); i_len_log2 = 3'(l); i_base = 5'(b); i_start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    i_start = 1'b0;
    i_mode = ~i_mode; i_base = ~i_base; i_len_log2 = ~i_len_log2;  // must not matter now
    k = 0; lat = -1;
    while (k < 200) begin
      if (o_done) begin lat = k; break; end
      @(posedge clk); @(negedge clk); k++;
    end
    res = int'(o_result);
    n = 1 << ((l > 5) ? 5 : l);
    nrd = addr_q.size();
    addr_ok = (nrd == n) ? 1 : 0;
    for (int i = 0; i < nrd && i < n; i++)
      if (int'(addr_q[i]) != (b + i) % 32) addr_ok = 0;
    @(posedge clk); @(negedge clk);
    check("done_pulse_width", int'(o_done), 0);
    check("result_hold", int'(o_result), res);
  endtask

  typedef struct {
    int mode;
    int len;
    int base;
    int fill;
    int exp;
  } vec_t;

  initial begin
    vec_t tv [14];
    int res, lat, nrd, aok, n, cnt, prev_rdy, m, l, b;
    int b2b_exp [3];
`ifdef MEAN_ROUND_EN
    int mean32 = 16;
    int mean4  = 16;
`else
    int mean32 = 15;
    int mean4  = 15;
`endif
    tv[0]  = '{0, 5, 0,  0, mean32};
    tv[1]  = '{1, 5, 0,  0, 0};
    tv[2]  = '{2, 5, 0,  0, 31};
    tv[3]  = '{3, 5, 0,  0, 496};
    tv[4]  = '{0, 2, 30, 0, mean4};
    tv[5]  = '{0, 0, 7,  2, 200};
    tv[6]  = '{1, 0, 7,  2, 200};
    tv[7]  = '{2, 0, 7,  2, 200};
    tv[8]  = '{3, 0, 7,  2, 200};
    tv[9]  = '{3, 7, 0,  1, 8160};
    tv[10] = '{0, 7, 0,  1, 255};
    tv[11] = '{1, 3, 28, 0, 0};
    tv[12] = '{2, 3, 28, 0, 31};
    tv[13] = '{3, 3, 28, 0, 28+29+30+31+0+1+2+3};

    i_rst_n = 1'b0; i_start = 1'b0; i_mode = '0; i_len_log2 = '0; i_base = '0;
    fill_mem(0);
    #2;
    check("reset_ready",   int'(o_ready),   1);
    check("reset_done",    int'(o_done),    0);
    check("reset_rd_en",   int'(o_rd_en),   0);
    check("reset_rd_addr", int'(o_rd_addr), 0);
    check("reset_result",  int'(o_result),  0);
    @(negedge clk); @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    foreach (tv[i]) begin
      fill_mem(tv[i].fill);
      do_run(tv[i].mode, tv[i].len, tv[i].base, res, lat, nrd, aok);
      n = 1 << ((tv[i].len > 5) ? 5 : tv[i].len);
      check($sformatf("vec%0d_result", i), res, tv[i].exp);
      check($sformatf("vec%0d_latency", i), lat, n + 2);
      check($sformatf("vec%0d_reads", i), nrd, n);
      check($sformatf("vec%0d_addr_seq", i), aok, 1);
    end

    // Back-to-back runs with start held high: one ready cycle between runs
    fill_mem(0);
    b2b_exp[0] = 0; b2b_exp[1] = 31; b2b_exp[2] = 496;
    i_mode = 2'd1; i_len_log2 = 3'd5; i_base = 5'd0; i_start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cnt = 0; prev_rdy = 1;
      while (cnt < 100) begin
        prev_rdy = int'(o_ready);
        @(posedge clk); @(negedge clk); cnt++;
        if (o_done) break;
      end
      check($sformatf("b2b%0d_done_seen", r), int'(o_done), 1);
      check($sformatf("b2b%0d_result", r), int'(o_result), b2b_exp[r]);
      check($sformatf("b2b%0d_busy_before", r), prev_rdy, 0);
      check($sformatf("b2b%0d_ready_gap", r), int'(o_ready), 1);
      if (r < 2) begin
        i_mode = 2'(r + 2);
        @(posedge clk); @(negedge clk);
        check($sformatf("b2b%0d_restart", r), int'(o_ready), 0);
      end else begin
        i_start = 1'b0;
      end
    end
    @(negedge clk);

    // Reset mid-run at i=10, after an ignored start request during RUN
    fill_mem(0);
    i_mode = 2'd3; i_len_log2 = 3'd5; i_base = 5'd0; i_start = 1'b1;
    @(posedge clk); @(negedge clk);
    i_start = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      if (cnt == 3) i_start = 1'b1;
      if (o_rd_en && o_rd_addr == 5'd10) break;
      @(posedge clk); @(negedge clk); cnt++;
    end
    check("rst_run_addr_at_i10", int'(o_rd_addr), 10);
    check("rst_run_ignored_start", int'(o_ready), 0);
    check("rst_prior_result", int'(o_result), 496);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_mid_ready",  int'(o_ready),  1);
    check("rst_mid_rd_en",  int'(o_rd_en),  0);
    check("rst_mid_result", int'(o_result), 0);
    check("rst_mid_done",   int'(o_done),   0);
    i_start = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done) cnt++;
    end
    check("rst_no_done", cnt, 0);
    do_run(3, 5, 0, res, lat, nrd, aok);
    check("rst_fresh_result", res, 496);
    check("rst_fresh_latency", lat, 34);

    // Randomized runs against the reference model
    for (int t = 0; t < 25; t++) begin
      fill_mem(3);
      m = int'($urandom_range(0, 3));
      l = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 31));
      do_run(m, l, b, res, lat, nrd, aok);
      n = 1 << ((l > 5) ? 5 : l);
      check($sformatf("rnd%0d_m%0d_l%0d_b%0d_result", t, m, l, b), res, model(m, l, b));
      check($sformatf("rnd%0d_latency", t), lat, n + 2);
      check($sformatf("rnd%0d_addr_seq", t), aok, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mean_engine_param.md
Name: mean_engine_param

Overview:
- Parametrised successor to the team's fixed 32-sample, 8-bit mean block.
- Streams 2^len_log2 samples from an external synchronous-read memory starting at a programmable base address.
- Computes one of four statistics per run (mean, min, max, sum), selected at start.
- Sits between a sample ROM/RAM and the result consumer; start/ready/done handshake.

Parameters:
DATA_W, 8, sample width in bits
ADDR_W, 5, memory address width; maximum run length 2^ADDR_W samples
RES_W, DATA_W+ADDR_W, result width; holds the full unsaturated sum

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  request new run; sampled only while ready=1
mode  input  2  00 mean, 01 min, 10 max, 11 sum; latched at start
len_log2  input  $clog2(ADDR_W+1)  run length exponent; latched at start
base  input  ADDR_W  first sample address; latched at start
rd_en  output  1  memory read strobe
rd_addr  output  ADDR_W  memory read address
rd_data  input  DATA_W  memory data, valid one cycle after rd_en
ready  output  1  idle, able to accept start
done  output  1  one-cycle pulse: result valid
result  output  RES_W  statistic; mean/min/max zero-extended

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE, ready=1, done=0, rd_en=0, rd_addr=0, result=0.
  - Accumulator, counter and latched fields cleared.
  - A run in progress is abandoned; no done pulse.
- States: IDLE -> RUN -> DRAIN -> FINISH -> IDLE.
- IDLE:
  - ready=1.
  - start=1 at edge E0 latches mode, base and len_log2, then enters RUN.
  - len_log2 > ADDR_W is clamped to ADDR_W.
  - N = 2^len_log2.
- RUN:
  - ready=0, rd_en=1.
  - rd_addr = base + i for i = 0..N-1; one address per cycle.
  - Address wraps modulo 2^ADDR_W.
  - After N issue cycles, go to DRAIN.
- Accumulate/compare:
  - Each rd_data is consumed on the edge after its read.
  - Sum accumulator is RES_W wide; it cannot overflow.
  - min/max registers are seeded from the first sample.
- DRAIN: consumes the final sample (rd_en=0), then FINISH.
- FINISH:
  - result registered per mode; done=1 for exactly one cycle; return to IDLE.
  - Mean = sum >> len_log2 (truncation unless MEAN_ROUND_EN is defined).
- Latency: done high in the cycle after edge E0+N+2.
  - N=32: done after E0+34.
  - N=1: done after E0+3.
- result holds its value until the next FINISH or reset.
- start while ready=0 is ignored; it is not queued.
- start held high through done: a new run starts on the first IDLE edge, so there is one ready cycle between runs.
- mode, len_log2, base and rd_data changes outside their sampling points have no effect.
- rd_data is treated as unsigned.

Optional Feature:
MEAN_ROUND_EN
- Defined: mean = (sum + 2^(len_log2-1)) >> len_log2.
  - Round half up.
  - For len_log2=0, no bias is added.
  - The addition is done at RES_W+1 bits, so there is no overflow.
- Undefined: mean truncates.
- min, max and sum are unaffected either way.

Test Plan:
1. Memory[a]=a (a=0..31), base=0, len_log2=5, mode=00:
   - rd_addr 0..31 consecutively.
   - done after E0+34.
   - result=15; 16 with MEAN_ROUND_EN.
2. Same data, modes 01, 10, 11 on back-to-back runs with start held high:
   - Results 0, 31, 496 in turn.
   - ready high for exactly one cycle between runs.
3. base=30, len_log2=2, mode=00, memory[a]=a:
   - rd_addr sequence 30, 31, 0, 1.
   - sum 62, result=15; 16 with MEAN_ROUND_EN.
4. len_log2=0, base=7, memory[7]=200, all modes:
   - Single read; result=200 for every mode.
   - done after E0+3.
5. len_log2=7 (clamped to 5), all memory=255, mode=11:
   - Exactly 32 reads; result=8160.
   - mode=00 gives 255.
6. rst pulsed low mid-RUN at i=10, with start asserted during RUN before that:
   - Immediate ready=1, rd_en=0, result=0, no done.
   - The earlier start during RUN is ignored.
   - A fresh run after reset gives the correct result.
